// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the iterative RV M-extension unit: funct3 codes, FSM states, op helpers.
package riscv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv_divu_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, XLEN cycles after start.
module riscv_divu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  localparam int unsigned   CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            run;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // rem < divisor always holds, so the trial MSB is set exactly when the subtraction borrows
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, dsr};
  assign done    = run && (cnt == LAST);
  assign q       = quo;
  assign r       = rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
    end else if (run) begin
      if (trial[XLEN]) begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end else begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with valid/ready on both sides.
// Optional MULDIV_REUSE_EN keeps the last div-class result so a matching DIV/REM completes in one cycle.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned     MUL_CYC  = XLEN / MUL_STEP;
  localparam int unsigned     MCW      = $clog2(MUL_CYC);
  localparam logic [MCW-1:0]  MUL_LAST = MCW'(MUL_CYC - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic            accept;
  logic            reuse_hit;
  logic [XLEN-1:0] hit_q_val;
  logic [XLEN-1:0] hit_r_val;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            hit_q;
  logic            sign_q, sign_r;
  logic            spec_flag;
  logic [XLEN-1:0] spec_q, spec_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [MCW-1:0]  mul_cnt;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_q, div_r;

  logic [MUL_STEP-1:0]        digit;
  logic [XLEN+MUL_STEP-1:0]   partial, hi_sum;
  logic [2*XLEN+MUL_STEP-1:0] wide;
  logic [2*XLEN-1:0]          acc_step, prod;
  logic [XLEN-1:0]            fin_q, fin_r, fix_result;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

`ifdef MULDIV_REUSE_EN
  logic            keep_valid, keep_signed;
  logic [XLEN-1:0] keep_a, keep_b, keep_q, keep_r;

  assign reuse_hit = keep_valid && is_div(in_op) && (in_a == keep_a) && (in_b == keep_b)
                     && (keep_signed == !in_op[0]);
  assign hit_q_val = keep_q;
  assign hit_r_val = keep_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_valid  <= 1'b0;
      keep_signed <= 1'b0;
      keep_a      <= '0;
      keep_b      <= '0;
      keep_q      <= '0;
      keep_r      <= '0;
    end else if (state == S_FIX && is_div(op_q) && !hit_q) begin
      keep_valid  <= 1'b1;
      keep_signed <= !op_q[0];
      keep_a      <= a_q;
      keep_b      <= b_q;
      keep_q      <= fin_q;
      keep_r      <= fin_r;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign hit_q_val = '0;
  assign hit_r_val = '0;
`endif

  // Operand magnitudes and sign bookkeeping, used while in PREP
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (is_div(op_q)) begin
      a_signed = !op_q[0];
      b_signed = !op_q[0];
    end else if (op_q == OP_MULH) begin
      a_signed = 1'b1;
      b_signed = 1'b1;
    end else if (op_q == OP_MULHSU) begin
      a_signed = 1'b1;
    end
    a_neg    = a_signed && a_q[XLEN-1];
    b_neg    = b_signed && b_q[XLEN-1];
    mag_a    = a_neg ? -a_q : a_q;
    mag_b    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    div_ovf  = !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
    special  = is_div(op_q) && (div_zero || div_ovf);
  end

  // Radix-2^MUL_STEP shift-add: add mcand*digit into the upper half, then shift right
  always_comb begin
    digit    = acc[MUL_STEP-1:0];
    partial  = {{MUL_STEP{1'b0}}, mcand} * {{XLEN{1'b0}}, digit};
    hi_sum   = {{MUL_STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
    wide     = {hi_sum, acc[XLEN-1:0]};
    acc_step = wide[2*XLEN+MUL_STEP-1:MUL_STEP];
  end

  always_comb begin
    prod  = sign_q ? -acc : acc;
    fin_q = spec_flag ? spec_q : (sign_q ? -div_q : div_q);
    fin_r = spec_flag ? spec_r : (sign_r ? -div_r : div_r);
    if (hit_q) begin
      fin_q = hit_q_val;
      fin_r = hit_r_val;
    end
    if (is_div(op_q))        fix_result = op_q[1] ? fin_r : fin_q;
    else if (op_q == OP_MUL) fix_result = prod[XLEN-1:0];
    else                     fix_result = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = reuse_hit ? S_FIX : S_PREP;
      S_PREP: begin
        if (!is_div(op_q)) begin
          state_nxt = S_MUL;
        end else if (special) begin
          state_nxt = S_FIX;
        end else begin
          state_nxt = S_DIV;
          div_start = 1'b1;
        end
      end
      S_MUL:  if (mul_cnt == MUL_LAST) state_nxt = S_FIX;
      S_DIV:  if (div_done) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hit_q      <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      spec_flag  <= 1'b0;
      spec_q     <= '0;
      spec_r     <= '0;
      acc        <= '0;
      mcand      <= '0;
      mul_cnt    <= '0;
      out_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= in_op;
          a_q   <= in_a;
          b_q   <= in_b;
          hit_q <= reuse_hit;
        end
        S_PREP: begin
          sign_q    <= a_neg ^ b_neg;
          sign_r    <= a_neg;
          spec_flag <= special;
          spec_q    <= div_zero ? '1 : a_q;
          spec_r    <= div_zero ? a_q : '0;
          acc       <= {{XLEN{1'b0}}, mag_b};
          mcand     <= mag_a;
          mul_cnt   <= '0;
        end
        S_MUL: begin
          acc     <= acc_step;
          mul_cnt <= mul_cnt + 1'b1;
        end
        S_FIX: out_result <= fix_result;
        default: ;
      endcase
    end
  end

  riscv_divu_iter #(.XLEN(XLEN)) u_divu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv (XLEN=32, MUL_STEP=2): arithmetic reference model plus directed vectors.
module tb_riscv_muldiv;
  import riscv_muldiv_pkg::*;

  localparam int XL  = 32;
  localparam int MST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [XL-1:0] in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [XL-1:0] out_result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [XL-1:0] exp_res = '0;

  bit            last_ok = 0;
  logic [XL-1:0] last_a, last_b;
  bit            last_s;

  typedef struct {
    logic [2:0]    op;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [XL-1:0] lit;
    bit            has_lit;
    int            hold;
  } vec_t;
  vec_t vecs[$];

  riscv_muldiv #(.XLEN(XL), .MUL_STEP(MST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [XL-1:0] ref_result(input logic [2:0] op, input logic [XL-1:0] a,
                                               input logic [XL-1:0] b);
    longint     sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    bit         ovf;
    sa   = $signed(a);
    sb   = $signed(b);
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    ub_s = ub;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    case (op)
      OP_MUL:    begin p = ua * ub;   return p[31:0];  end
      OP_MULH:   begin p = sa * sb;   return p[63:32]; end
      OP_MULHSU: begin p = sa * ub_s; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;   return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return '1;
        p = ua / ub;
        return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [XL-1:0] a,
                                     input logic [XL-1:0] b);
    if (!op[2]) return XL / MST + 2;
`ifdef MULDIV_REUSE_EN
    if (last_ok && last_a == a && last_b == b && last_s == !op[0]) return 1;
`endif
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return XL + 2;
  endfunction

  // Whenever a result is presented it must match the model and the unit must look busy
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("result", out_result, exp_res);
      check("busy_while_valid", {31'd0, busy}, 32'd1);
      check("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
    end
  end

  task automatic do_req(input vec_t v);
    int lat, exp_lat;
    check("idle_before_req", {31'd0, in_ready}, 32'd1);
    exp_res  = ref_result(v.op, v.a, v.b);
    exp_lat  = ref_latency(v.op, v.a, v.b);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", v.op), lat, exp_lat);
    if (v.has_lit) check($sformatf("literal op%0d", v.op), out_result, v.lit);
    if (v.op[2]) begin
      last_ok = 1;
      last_a  = v.a;
      last_b  = v.b;
      last_s  = !v.op[0];
    end
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1;
      in_op    = OP_MUL;
      in_a     = $urandom;
      in_b     = $urandom;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_valid", {31'd0, out_valid}, 32'd0);
    check("consumed_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0});
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 5});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1, 0});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0});
    vecs.push_back('{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 0});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0});
    vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         32'd14,        1, 0});
    vecs.push_back('{OP_REMU,   32'd100,       32'd7,         32'd2,         1, 0});
    vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0});
    vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1, 0});
    vecs.push_back('{OP_DIVU,   32'd3,         32'd10,        32'd0,         1, 0});
    vecs.push_back('{OP_REMU,   32'd3,         32'd10,        32'd3,         1, 0});
    vecs.push_back('{OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         0, 0});
    vecs.push_back('{OP_MULH,   32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         0, 0});
    vecs.push_back('{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 0});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'd3,         32'h0,         0, 0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_req(vecs[i]);

    // Abort a DIV ten cycles in; the previously completed entry must not survive reset
    do_req('{OP_DIVU, 32'd1000, 32'd9, 32'd111, 1, 0});
    exp_res  = ref_result(OP_DIV, 32'd500, 32'd3);
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd500; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    last_ok = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req('{OP_DIVU, 32'd1000, 32'd9, 32'd111, 1, 0});
    do_req('{OP_DIV,  32'd500,  32'd3, 32'd166, 1, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
